wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Write-side master for the register file: merges single-cycle results (ALU/LUI/JAL) and
//  results from multi-cycle units (load, mul/div) onto the RF's single write port (wR/we/wD).
//  Buffers late results in a small FIFO and tracks destinations with pending writes in a scoreboard.
//  Raises a stall request when the buffered path is being starved.
//  Sits between the execute/memory units and the RF, in the cpu_clk domain.
// PARAMETERS
//  DEPTH       4   secondary FIFO entries (power of 2, >=2)
//  STARVE_LIM  4   consecutive cycles FIFO full and blocked before stall_req
//  DATA_W      32  result width
// PORTS
//  cpu_clk    in   1       clock; all state updates on posedge
//  cpu_rst    in   1       synchronous, active-high reset
//  pri_we     in   1       primary (single-cycle) write request, no backpressure
//  pri_rd     in   5       primary destination register
//  pri_wd     in   DATA_W  primary write data
//  sec_valid  in   1       secondary result valid
//  sec_ready  out  1       secondary accept (= FIFO not full, from registered count)
//  sec_rd     in   5       secondary destination register
//  sec_wd     in   DATA_W  secondary write data
//  iss_valid  in   1       multi-cycle op issued this cycle (marks rd pending)
//  iss_rd     in   5       destination of the issued op
//  wR         out  5       RF write address
//  we         out  1       RF write enable
//  wD         out  DATA_W  RF write data
//  pend_mask  out  32      bit n=1: register xn has an outstanding secondary write
//  stall_req  out  1       core must hold the primary path idle this cycle
//  err        out  1       sticky protocol error flag
// BEHAVIOUR
//  Reset: FIFO flushed, count=0, pend_mask=0, starve counter=0.
//   Reset outputs: we=0, wR=0, wD=0, stall_req=0, err=0, sec_ready=0 while cpu_rst=1.
//  Write port is combinational, sampled by the RF at the next posedge (0-cycle primary latency).
//  Priority: pri_we=1 and pri_rd!=0 -> wR=pri_rd, wD=pri_wd, we=1. FIFO head is held.
//   Otherwise, if FIFO non-empty -> drive head to wR/wD, we=1, pop at posedge.
//   Otherwise we=0, wR=0, wD=0.
//  x0: primary writes to rd=0 give we=0 and leave the slot free for the FIFO.
//   Secondary results with rd=0 are accepted but not enqueued.
//  Secondary handshake: transfer when sec_valid & sec_ready. Data is enqueued at the posedge.
//   Earliest RF write is the following cycle (latency >=1).
//   sec_valid may not drop before the transfer. Push and pop in the same cycle keep count unchanged.
//  sec_ready is deasserted when count==DEPTH, even if a pop occurs that cycle (no fall-through).
//  Scoreboard:
//   - iss_valid & iss_rd!=0 sets pend[iss_rd].
//   - Popping an entry clears pend[entry.rd].
//   - Set and clear of the same index in one cycle: set wins.
//   - Issue to an already-pending register sets err.
//  Starvation: counter increments each cycle with count==DEPTH and a primary write (rd!=0) active.
//   It clears otherwise. counter>=STARVE_LIM -> stall_req=1 (registered).
//   While stall_req=1 the core holds pri_we=0; the pop clears the counter and stall_req next cycle.
//  err (sticky until reset) is also set by:
//   - sec transfer with rd!=0 whose pend bit is clear;
//   - pri_we with pri_rd pending (WAW race);
//   - a transfer attempted while count==DEPTH.
//  Reset mid-operation: buffered results are discarded, no RF write occurs in the reset cycle.
//  FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
// STRUCTURE
//  defines.vh: `REG_AW (5), `ZERO_REG (5'd0), reset values for wR/wD.
//  Sub-module wb_fifo (synchronous FIFO, params DEPTH/WIDTH=5+DATA_W; push/pop/full/empty/count).
//  Top holds the priority mux, scoreboard register, starve counter and err logic.
// TESTING
//  1. Reset: pulse cpu_rst during traffic -> next cycle we=0, pend_mask=0, sec_ready=1, err=0.
//  2. Primary only: pri_we=1, rd=5, wd=0x1234 -> same cycle wR=5, wD=0x1234, we=1.
//     rd=0 -> we=0.
//  3. Secondary only: iss rd=7; 3 cycles later sec rd=7, wd=0xCAFE -> next cycle wR=7, we=1.
//     pend[7] 1 -> 0 after the pop.
//  4. Conflict: FIFO holds rd=9; primary rd=3 active for 2 cycles -> head held.
//     Write to x9 lands the first primary-idle cycle.
//  5. Starvation: fill 4 entries, continuous primary writes -> stall_req=1 after 4 cycles.
//     With primary idle, one pop per cycle until empty.
//  6. Errors: issue rd=4 twice -> err=1 (sticky). Fresh run: pri rd=4 while pend[4] -> err=1.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared register-file addressing types and helpers for the write-back arbiter.
// Holds the x0 constant and the reset values driven on the RF write address.
package wb_arbiter_pkg;

  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [REG_AW-1:0]   reg_addr_t;
  typedef logic [NUM_REGS-1:0] reg_mask_t;

  localparam reg_addr_t ZERO_REG = '0;
  localparam reg_addr_t WR_RST   = '0;

  // One-hot mask for a destination; x0 never appears in the scoreboard.
  function automatic reg_mask_t reg_onehot(input reg_addr_t a);
    reg_mask_t m;
    m = '0;
    if (a != ZERO_REG) m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Synchronous FIFO for buffered secondary results; 1-cycle push-to-head latency.
// No fall-through: push is refused while full even if a pop happens the same cycle.
module wb_arbiter_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 37,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign head_dat = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full && !rst;
    do_pop   = pop && !empty && !rst;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: primary results win with 0-cycle latency, buffered
// secondary results drain in idle slots (>=1 cycle); sec_ready drops when the FIFO is full.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 4,
  parameter int DATA_W     = 32
) (
  input  logic                cpu_clk,
  input  logic                cpu_rst,
  input  logic                pri_we,
  input  logic [REG_AW-1:0]   pri_rd,
  input  logic [DATA_W-1:0]   pri_wd,
  input  logic                sec_valid,
  output logic                sec_ready,
  input  logic [REG_AW-1:0]   sec_rd,
  input  logic [DATA_W-1:0]   sec_wd,
  input  logic                iss_valid,
  input  logic [REG_AW-1:0]   iss_rd,
  output logic [REG_AW-1:0]   wR,
  output logic                we,
  output logic [DATA_W-1:0]   wD,
  output logic [NUM_REGS-1:0] pend_mask,
  output logic                stall_req,
  output logic                err
);

  localparam int EW = REG_AW + DATA_W;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIM + 1);

  logic            pri_act;
  logic            sec_xfer;
  logic            push;
  logic            pop;
  logic [EW-1:0]   head_dat;
  reg_addr_t       head_rd;
  logic [DATA_W-1:0] head_wd;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_cnt;

  reg_mask_t       pend_q, pend_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            err_q, err_d;

  wb_arbiter_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk      (cpu_clk),
    .rst      (cpu_rst),
    .push     (push),
    .push_dat ({sec_rd, sec_wd}),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  assign head_rd = head_dat[EW-1 -: REG_AW];
  assign head_wd = head_dat[DATA_W-1:0];

  // A primary write to x0 is a no-op and must not steal the slot from the FIFO.
  assign pri_act   = pri_we && (pri_rd != ZERO_REG);
  assign sec_ready = !cpu_rst && (fifo_cnt != CW'(DEPTH));
  assign sec_xfer  = sec_valid && sec_ready;
  assign push      = sec_xfer && (sec_rd != ZERO_REG);

  always_comb begin
    we  = 1'b0;
    wR  = WR_RST;
    wD  = '0;
    pop = 1'b0;
    if (!cpu_rst) begin
      if (pri_act) begin
        we = 1'b1;
        wR = pri_rd;
        wD = pri_wd;
      end else if (!fifo_empty) begin
        we  = 1'b1;
        wR  = head_rd;
        wD  = head_wd;
        pop = 1'b1;
      end
    end
  end

  // Clear is applied before set so an issue in the same cycle as the drain keeps the bit.
  always_comb begin
    pend_d = pend_q;
    if (pop)       pend_d = pend_d & ~reg_onehot(head_rd);
    if (iss_valid) pend_d = pend_d | reg_onehot(iss_rd);
  end

  always_comb begin
    err_d = err_q;
    if (iss_valid && (iss_rd != ZERO_REG) && pend_q[iss_rd])  err_d = 1'b1;
    if (sec_xfer && (sec_rd != ZERO_REG) && !pend_q[sec_rd])  err_d = 1'b1;
    if (pri_act && pend_q[pri_rd])                            err_d = 1'b1;
    if (sec_valid && fifo_full)                               err_d = 1'b1;
  end

  // Counter saturates at the limit so a long stall cannot wrap it back below.
  always_comb begin
    starve_d = '0;
    if (fifo_full && pri_act) begin
      if (starve_q < SW'(STARVE_LIM)) starve_d = starve_q + SW'(1);
      else                            starve_d = starve_q;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      pend_q   <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  assign pend_mask = pend_q;
  assign stall_req = !cpu_rst && (starve_q >= SW'(STARVE_LIM));
  assign err       = !cpu_rst && err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: queue-level reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int LIM   = 4;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic        pri_we = 1'b0;
  logic [4:0]  pri_rd = '0;
  logic [31:0] pri_wd = '0;
  logic        sec_valid = 1'b0;
  logic        sec_ready;
  logic [4:0]  sec_rd = '0;
  logic [31:0] sec_wd = '0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic [4:0]  wR;
  logic        we;
  logic [31:0] wD;
  logic [31:0] pend_mask;
  logic        stall_req;
  logic        err;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIM(LIM), .DATA_W(32)) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .pri_we    (pri_we),
    .pri_rd    (pri_rd),
    .pri_wd    (pri_wd),
    .sec_valid (sec_valid),
    .sec_ready (sec_ready),
    .sec_rd    (sec_rd),
    .sec_wd    (sec_wd),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .wR        (wR),
    .we        (we),
    .wD        (wD),
    .pend_mask (pend_mask),
    .stall_req (stall_req),
    .err       (err)
  );

  always #5 cpu_clk = ~cpu_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the buffered results as a plain queue, pending set as a bit vector.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  ent_t        mq[$];
  bit   [31:0] mpend = '0;
  bit          merr = 1'b0;
  int          mstarve = 0;
  bit          m_pa, m_pop, m_xfer;

  always @(posedge cpu_clk) begin
    if (cpu_rst) begin
      mq.delete();
      mpend   = '0;
      merr    = 1'b0;
      mstarve = 0;
    end else begin
      m_pa   = pri_we && (pri_rd != 0);
      m_pop  = !m_pa && (mq.size() > 0);
      m_xfer = sec_valid && (mq.size() < DEPTH);
      if (iss_valid && iss_rd != 0 && mpend[iss_rd]) merr = 1'b1;
      if (m_xfer && sec_rd != 0 && !mpend[sec_rd])   merr = 1'b1;
      if (m_pa && mpend[pri_rd])                     merr = 1'b1;
      if (sec_valid && mq.size() == DEPTH)           merr = 1'b1;
      if (mq.size() == DEPTH && m_pa) mstarve++;
      else                            mstarve = 0;
      if (m_pop) begin
        mpend[mq[0].rd] = 1'b0;
        void'(mq.pop_front());
      end
      if (iss_valid && iss_rd != 0) mpend[iss_rd] = 1'b1;
      if (m_xfer && sec_rd != 0) mq.push_back('{sec_rd, sec_wd});
    end
  end

  logic        e_we, e_rdy, e_stall, e_err;
  logic [4:0]  e_wr;
  logic [31:0] e_wd;

  always @(negedge cpu_clk) begin
    e_we = 1'b0; e_wr = '0; e_wd = '0; e_rdy = 1'b0; e_stall = 1'b0; e_err = 1'b0;
    if (!cpu_rst) begin
      if (pri_we && pri_rd != 0) begin
        e_we = 1'b1; e_wr = pri_rd; e_wd = pri_wd;
      end else if (mq.size() > 0) begin
        e_we = 1'b1; e_wr = mq[0].rd; e_wd = mq[0].wd;
      end
      e_rdy   = (mq.size() < DEPTH);
      e_stall = (mstarve >= LIM);
      e_err   = merr;
    end
    chk("mdl_we", 32'(we), 32'(e_we));
    chk("mdl_wR", 32'(wR), 32'(e_wr));
    chk("mdl_wD", wD, e_wd);
    chk("mdl_sec_ready", 32'(sec_ready), 32'(e_rdy));
    chk("mdl_stall_req", 32'(stall_req), 32'(e_stall));
    chk("mdl_err", 32'(err), 32'(e_err));
    chk("mdl_pend_mask", pend_mask, mpend);
  end

  task automatic next();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic settle();
    @(negedge cpu_clk);
    #1;
  endtask

  initial begin
    // Reset state
    next();
    settle();
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_sec_ready", 32'(sec_ready), 32'd0);
    next();
    cpu_rst = 1'b0;
    settle();
    chk("post_rst_ready", 32'(sec_ready), 32'd1);
    chk("post_rst_err", 32'(err), 32'd0);
    chk("post_rst_pend", pend_mask, 32'd0);
    next();

    // Primary only, then a write to x0
    pri_we = 1'b1; pri_rd = 5'd5; pri_wd = 32'h1234;
    settle();
    chk("pri_we", 32'(we), 32'd1);
    chk("pri_wR", 32'(wR), 32'd5);
    chk("pri_wD", wD, 32'h1234);
    next();
    pri_rd = 5'd0;
    settle();
    chk("pri_x0_we", 32'(we), 32'd0);
    next();
    pri_we = 1'b0;

    // Secondary only: issue x7, result three cycles later
    iss_valid = 1'b1; iss_rd = 5'd7;
    next();
    iss_valid = 1'b0;
    settle();
    chk("sec_pend_set", pend_mask, 32'h0000_0080);
    next();
    next();
    sec_valid = 1'b1; sec_rd = 5'd7; sec_wd = 32'hCAFE;
    settle();
    chk("sec_no_fallthru", 32'(we), 32'd0);
    next();
    sec_valid = 1'b0;
    settle();
    chk("sec_we", 32'(we), 32'd1);
    chk("sec_wR", 32'(wR), 32'd7);
    chk("sec_wD", wD, 32'hCAFE);
    chk("sec_pend_held", pend_mask, 32'h0000_0080);
    next();
    settle();
    chk("sec_pend_clr", pend_mask, 32'd0);
    next();

    // Conflict: buffered x9 waits behind two primary writes to x3
    iss_valid = 1'b1; iss_rd = 5'd9;
    next();
    iss_valid = 1'b0;
    sec_valid = 1'b1; sec_rd = 5'd9; sec_wd = 32'h99;
    next();
    sec_valid = 1'b0;
    pri_we = 1'b1; pri_rd = 5'd3; pri_wd = 32'h33;
    settle();
    chk("cfl_pri1_wR", 32'(wR), 32'd3);
    next();
    settle();
    chk("cfl_pri2_wD", wD, 32'h33);
    next();
    pri_we = 1'b0;
    settle();
    chk("cfl_sec_wR", 32'(wR), 32'd9);
    chk("cfl_sec_wD", wD, 32'h99);
    next();
    settle();
    chk("cfl_drained", 32'(we), 32'd0);
    next();

    // Starvation: fill while primary is busy, then keep primary busy
    for (int i = 0; i < 4; i++) begin
      iss_valid = 1'b1; iss_rd = 5'(10 + i);
      next();
    end
    iss_valid = 1'b0;
    pri_we = 1'b1; pri_rd = 5'd1; pri_wd = 32'h100;
    for (int i = 0; i < 4; i++) begin
      sec_valid = 1'b1; sec_rd = 5'(10 + i); sec_wd = 32'hA0 + 32'(i);
      next();
    end
    sec_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk("stv_no_stall", 32'(stall_req), 32'd0);
      chk("stv_full", 32'(sec_ready), 32'd0);
      next();
    end
    pri_we = 1'b0;
    settle();
    chk("stv_stall", 32'(stall_req), 32'd1);
    chk("stv_pop0_wR", 32'(wR), 32'd10);
    next();
    for (int i = 1; i < 4; i++) begin
      settle();
      chk("stv_pop_wR", 32'(wR), 32'(10 + i));
      chk("stv_stall_clr", 32'(stall_req), 32'd0);
      next();
    end
    settle();
    chk("stv_empty_we", 32'(we), 32'd0);
    chk("stv_pend_clr", pend_mask, 32'd0);
    next();

    // Double issue to x4 while an entry is buffered, then reset mid-traffic
    iss_valid = 1'b1; iss_rd = 5'd4;
    next();
    sec_valid = 1'b1; sec_rd = 5'd4; sec_wd = 32'h55;
    pri_we = 1'b1; pri_rd = 5'd2; pri_wd = 32'h22;
    next();
    iss_valid = 1'b0; sec_valid = 1'b0;
    settle();
    chk("dup_err", 32'(err), 32'd1);
    chk("dup_pend", pend_mask, 32'h0000_0010);
    next();
    settle();
    chk("err_sticky", 32'(err), 32'd1);
    next();
    pri_we = 1'b0;
    cpu_rst = 1'b1;
    settle();
    chk("mid_rst_we", 32'(we), 32'd0);
    chk("mid_rst_ready", 32'(sec_ready), 32'd0);
    next();
    cpu_rst = 1'b0;
    settle();
    chk("after_rst_we", 32'(we), 32'd0);
    chk("after_rst_pend", pend_mask, 32'd0);
    chk("after_rst_err", 32'(err), 32'd0);
    chk("after_rst_ready", 32'(sec_ready), 32'd1);
    next();

    // Secondary result for x0 is accepted and dropped
    sec_valid = 1'b1; sec_rd = 5'd0; sec_wd = 32'h77;
    settle();
    chk("x0_sec_ready", 32'(sec_ready), 32'd1);
    next();
    sec_valid = 1'b0;
    settle();
    chk("x0_sec_dropped", 32'(we), 32'd0);
    next();

    // WAW race: primary writes a register with an outstanding secondary write
    iss_valid = 1'b1; iss_rd = 5'd4;
    next();
    iss_valid = 1'b0;
    pri_we = 1'b1; pri_rd = 5'd4; pri_wd = 32'h44;
    settle();
    chk("waw_err_before", 32'(err), 32'd0);
    next();
    pri_we = 1'b0;
    settle();
    chk("waw_err", 32'(err), 32'd1);
    next();
    next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
